game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line:
- LIVES, 3: lives loaded at game start (1..3).
- SERVE_DELAY, 60: frames ball held before launch (1..255).
- MISS_HOLD, 30: frames of freeze after a miss (1..255).
- KEY_START, 8'h2C: start key (space).
- KEY_PAUSE, 8'h13: pause toggle key (P).
- KEY_RESTART, 8'h28: restart key (enter).
REQ-002 The block SHALL have ports, one per line:
- frame_clk  in  1  frame clock; sole clock.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  raw keyboard code, 0 = no key.
- Ball_Miss  in  1  level; ball below bar line this frame.
- Brick_Hit  in  1  one-frame pulse per brick destroyed.
- Bricks_Clear  in  1  level; no bricks remain.
- Bar_Key  out  8  keycode forwarded to bar datapath.
- Bar_Reset  out  1  recentre bar.
- Ball_Reset  out  1  hold ball at serve position.
- Ball_Run  out  1  ball motion enabled.
- Lives  out  2  remaining lives.
- Score  out  10  bricks destroyed, saturating.
- State  out  3  current state code.
- Game_Over  out  1  loss indication.
- Game_Win  out  1  win indication.
REQ-003 The block SHALL use one clock, frame_clk, with an asynchronous, active-high Reset; all state SHALL update only on the posedge of frame_clk or the posedge of Reset.

Function
REQ-004 A key event SHALL be a one-frame condition where keycode equals the key and the registered previous keycode did not; a held key SHALL produce exactly one event.
REQ-005 States and their State codes SHALL be IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5, PAUSE=6; code 7 SHALL recover to IDLE on the next frame.
REQ-006 The outputs SHALL be a Moore decode of state:
- Bar_Reset=1 in IDLE and MISS.
- Ball_Reset=1 in IDLE, SERVE, MISS, OVER and WIN.
- Ball_Run=1 only in PLAY.
- Game_Over=1 only in OVER.
- Game_Win=1 only in WIN.
REQ-007 Bar_Key SHALL equal keycode in SERVE and PLAY and SHALL be 8'h00 in all other states, which freezes the bar.
REQ-008 IDLE: a KEY_START event SHALL move the block to SERVE, load Lives=LIVES, clear Score to 0, and load the frame counter with SERVE_DELAY-1.
REQ-009 SERVE: the counter SHALL decrement once per frame; in the frame where the counter is 0, the next state SHALL be PLAY.
REQ-010 PLAY: priority SHALL be Bricks_Clear, then Ball_Miss, then the KEY_PAUSE event.
- Bricks_Clear -> WIN.
- Ball_Miss -> MISS, Lives decremented by 1 (saturating at 0), counter loaded with MISS_HOLD-1.
- KEY_PAUSE event -> PAUSE.
REQ-011 Each Brick_Hit frame in PLAY SHALL increment Score by 1, saturating at 999; this increment SHALL still apply in the same frame as Bricks_Clear or Ball_Miss.
REQ-012 Brick_Hit, Ball_Miss and Bricks_Clear SHALL be ignored in every state other than PLAY.
REQ-013 PAUSE: a KEY_PAUSE event SHALL return to PLAY; the counter, Lives and Score SHALL hold.
REQ-014 MISS: the counter SHALL decrement once per frame; in the frame where the counter is 0, the next state SHALL be:
- OVER if Lives==0;
- otherwise SERVE, with the counter reloaded to SERVE_DELAY-1.
REQ-015 OVER and WIN: a KEY_RESTART event SHALL move the block to IDLE; Lives and Score SHALL hold until the next KEY_START.
REQ-016 The counter SHALL be 8 bits and SHALL never wrap below 0.

Reset
REQ-017 Reset SHALL force, asynchronously:
- state=IDLE and counter=0;
- Lives=LIVES and Score=0;
- previous-keycode register=8'h00.
The outputs SHALL therefore be Bar_Reset=1, Ball_Reset=1, Ball_Run=0, Bar_Key=0, State=0, Game_Over=0 and Game_Win=0.
REQ-018 Reset asserted in any state, including mid-count, SHALL take effect immediately; Reset released SHALL resume from IDLE.

Verification
REQ-019 Start/serve: Reset; keycode=2C held 5 frames -> exactly one transition to SERVE; Ball_Run=1 exactly 60 frames after entering SERVE; Lives=3, Score=0.
REQ-020 Miss sequence: in PLAY, one Ball_Miss frame -> MISS, Lives=2, Bar_Reset=1, Bar_Key=0 for 30 frames, then SERVE.
REQ-021 Game over: three misses with LIVES=3 -> Lives=0, then OVER with Game_Over=1; KEY_RESTART event -> IDLE.
REQ-022 Score and win: 5 Brick_Hit pulses then Brick_Hit together with Bricks_Clear -> Score=6, WIN, Game_Win=1; Brick_Hit in WIN -> Score stays 6.
REQ-023 Pause: in PLAY, P pressed -> PAUSE, Ball_Run=0; Ball_Miss in PAUSE -> Lives unchanged; P released and pressed again -> PLAY.
REQ-024 Async reset: Reset pulsed mid-MISS count -> immediate IDLE with Lives=3, Score=0, without waiting for a frame_clk edge.

Source files
------------

// File: rtl/game_sequencer.sv
// Breakout-style game sequencer: serve/play/miss/pause/win/lose flow, lives and score.
// One frame_clk tick per video frame; all sequencing counts are in frames.
module game_sequencer #(
    parameter int          LIVES       = 3,
    parameter int          SERVE_DELAY = 60,
    parameter int          MISS_HOLD   = 30,
    parameter logic [7:0]  KEY_START   = 8'h2C,
    parameter logic [7:0]  KEY_PAUSE   = 8'h13,
    parameter logic [7:0]  KEY_RESTART = 8'h28
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic        Ball_Miss,
    input  logic        Brick_Hit,
    input  logic        Bricks_Clear,
    output logic [7:0]  Bar_Key,
    output logic        Bar_Reset,
    output logic        Ball_Reset,
    output logic        Ball_Run,
    output logic [1:0]  Lives,
    output logic [9:0]  Score,
    output logic [2:0]  State,
    output logic        Game_Over,
    output logic        Game_Win
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY - 1);
    localparam logic [7:0] MISS_LOAD  = 8'(MISS_HOLD - 1);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES);
    localparam logic [9:0] SCORE_MAX  = 10'd999;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lives;
    logic [9:0]  r_score;
    logic [7:0]  r_prev_key;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  w_lives_nxt;
    logic [9:0]  w_score_nxt;
    logic        w_start_ev;
    logic        w_pause_ev;
    logic        w_restart_ev;

    // A key event is the first frame a key appears, so a held key fires once.
    assign w_start_ev   = (keycode == KEY_START)   && (r_prev_key != KEY_START);
    assign w_pause_ev   = (keycode == KEY_PAUSE)   && (r_prev_key != KEY_PAUSE);
    assign w_restart_ev = (keycode == KEY_RESTART) && (r_prev_key != KEY_RESTART);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_lives    <= LIVES_LOAD;
            r_score    <= 10'd0;
            r_prev_key <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lives    <= w_lives_nxt;
            r_score    <= w_score_nxt;
            r_prev_key <= keycode;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        case (r_state)
            S_IDLE: begin
                if (w_start_ev) begin
                    w_state_nxt = S_SERVE;
                    w_lives_nxt = LIVES_LOAD;
                    w_score_nxt = 10'd0;
                    w_cnt_nxt   = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_PLAY: begin
                // Score still counts the brick hit that clears the wall or coincides with a miss.
                if (Brick_Hit && (r_score != SCORE_MAX)) begin
                    w_score_nxt = r_score + 10'd1;
                end
                if (Bricks_Clear) begin
                    w_state_nxt = S_WIN;
                end else if (Ball_Miss) begin
                    w_state_nxt = S_MISS;
                    w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                    w_cnt_nxt   = MISS_LOAD;
                end else if (w_pause_ev) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_ev) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_MISS: begin
                if (r_cnt == 8'd0) begin
                    if (r_lives == 2'd0) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_state_nxt = S_SERVE;
                        w_cnt_nxt   = SERVE_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_OVER, S_WIN: begin
                // Lives and Score stay visible on the end screen until the next start.
                if (w_restart_ev) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Bar_Reset  = 1'b0;
        Ball_Reset = 1'b0;
        Ball_Run   = 1'b0;
        Game_Over  = 1'b0;
        Game_Win   = 1'b0;
        Bar_Key    = 8'h00;
        case (r_state)
            S_IDLE: begin
                Bar_Reset  = 1'b1;
                Ball_Reset = 1'b1;
            end
            S_SERVE: begin
                Ball_Reset = 1'b1;
                Bar_Key    = keycode;
            end
            S_PLAY: begin
                Ball_Run = 1'b1;
                Bar_Key  = keycode;
            end
            S_MISS: begin
                Bar_Reset  = 1'b1;
                Ball_Reset = 1'b1;
            end
            S_OVER: begin
                Ball_Reset = 1'b1;
                Game_Over  = 1'b1;
            end
            S_WIN: begin
                Ball_Reset = 1'b1;
                Game_Win   = 1'b1;
            end
            default: begin
                Bar_Key = 8'h00;
            end
        endcase
    end

    assign Lives = r_lives;
    assign Score = r_score;
    assign State = r_state;

endmodule
